// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID/EX and EX/MEM.
// Single-cycle logic/shift/arith/LUI results are combinational. MUL/MULH use an
// iterative shift-add multiplier that holds stallreq_o until the product is ready.
// Build option: define FAST_MUL_EN to replace the iterative multiplier with a
// single-cycle combinational product (stallreq_o then stays 0).

package ex_stage_pkg;
   // result classes (alusel)
   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
   localparam logic [2:0] EXE_RES_ARITH = 3'b100;
   localparam logic [2:0] EXE_RES_MUL   = 3'b101;
   // operation codes (aluop)
   localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_LUI_OP  = 8'b0000_1111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
   localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
   localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [7:0] EXE_MUL_OP  = 8'b1010_1001;
   localparam logic [7:0] EXE_MULH_OP = 8'b1010_1010;
endpackage

module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALUOP_W  = 8,
   parameter int unsigned ALUSEL_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic [ALUOP_W-1:0]  aluop_i,
   input  logic [ALUSEL_W-1:0] alusel_i,
   input  logic [XLEN-1:0]     reg1_i,
   input  logic [XLEN-1:0]     reg2_i,
   input  logic [4:0]          wd_i,
   input  logic                wreg_i,
   output logic [4:0]          wd_o,
   output logic                wreg_o,
   output logic [XLEN-1:0]     wdata_o,
   output logic                stallreq_o
);

   localparam int unsigned PW = 2 * XLEN;

   logic            is_mul;
   logic            is_mulh;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] mul_res;
   logic            mul_sel;
   logic            mul_stall;
   logic            mul_wr_ok;

   assign is_mulh = (alusel_i == EXE_RES_MUL) && (aluop_i == EXE_MULH_OP);
   assign is_mul  = (alusel_i == EXE_RES_MUL) && ((aluop_i == EXE_MUL_OP) || is_mulh);

   // single-cycle result mux: class first, then operation within the class
   always_comb begin
      alu_res = '0;
      case (alusel_i)
         EXE_RES_LOGIC: begin
            case (aluop_i)
               EXE_OR_OP:  alu_res = reg1_i | reg2_i;
               EXE_AND_OP: alu_res = reg1_i & reg2_i;
               EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
               EXE_LUI_OP: alu_res = reg2_i;
               default:    alu_res = '0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: alu_res = reg1_i << reg2_i[4:0];
               EXE_SRL_OP: alu_res = reg1_i >> reg2_i[4:0];
               EXE_SRA_OP: alu_res = $signed(reg1_i) >>> reg2_i[4:0];
               default:    alu_res = '0;
            endcase
         end
         EXE_RES_ARITH: begin
            case (aluop_i)
               EXE_ADD_OP:  alu_res = reg1_i + reg2_i;
               EXE_SUB_OP:  alu_res = reg1_i - reg2_i;
               EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
               EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, (reg1_i < reg2_i)};
               default:     alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

`ifdef FAST_MUL_EN

   logic [PW-1:0] prod_u;
   logic [PW-1:0] prod_s;

   // combinational product: unsigned for MUL (low word), signed x signed for MULH
   always_comb begin
      prod_u    = {{XLEN{1'b0}}, reg1_i} * {{XLEN{1'b0}}, reg2_i};
      prod_s    = $signed({{XLEN{reg1_i[XLEN-1]}}, reg1_i}) *
                  $signed({{XLEN{reg2_i[XLEN-1]}}, reg2_i});
      mul_res   = is_mulh ? prod_s[PW-1:XLEN] : prod_u[XLEN-1:0];
      mul_sel   = is_mul;
      mul_stall = 1'b0;
      mul_wr_ok = 1'b1;
   end

`else

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam int unsigned CW = $clog2(XLEN);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic            sign_q, sign_d;
   logic            mulh_q, mulh_d;
   logic [XLEN-1:0] abs1;
   logic [XLEN-1:0] abs2;
   logic [PW-1:0]   prod;

   // MULH multiplies magnitudes and restores the sign at the end; MUL uses raw bits
   assign abs1 = (is_mulh && reg1_i[XLEN-1]) ? (~reg1_i + 1'b1) : reg1_i;
   assign abs2 = (is_mulh && reg2_i[XLEN-1]) ? (~reg2_i + 1'b1) : reg2_i;

   // multiplier state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         mulh_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         mulh_q   <= mulh_d;
      end
   end

   // multiplier next state and stall/write qualification; flush overrides everything
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sign_d    = sign_q;
      mulh_d    = mulh_q;
      mul_stall = 1'b0;
      mul_wr_ok = 1'b1;
      mul_sel   = 1'b0;
      mul_res   = '0;
      prod      = sign_q ? (~acc_q + 1'b1) : acc_q;
      case (state_q)
         S_IDLE: begin
            if (is_mul) begin
               mul_stall = 1'b1;
               mul_wr_ok = 1'b0;
               mcand_d   = {{XLEN{1'b0}}, abs1};
               mplier_d  = abs2;
               acc_d     = '0;
               sign_d    = is_mulh & (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
               mulh_d    = is_mulh;
               cnt_d     = '0;
               state_d   = S_BUSY;
            end
         end
         S_BUSY: begin
            mul_stall = 1'b1;
            mul_wr_ok = 1'b0;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            mul_sel = 1'b1;
            mul_res = mulh_q ? prod[PW-1:XLEN] : prod[XLEN-1:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         acc_d     = '0;
         sign_d    = 1'b0;
         mul_stall = 1'b0;
      end
   end

`endif

   // writeback outputs: reset forces zero, flush and multiply-in-progress suppress the write
   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i & mul_wr_ok & ~flush_i;
      wdata_o    = mul_sel ? mul_res : alu_res;
      stallreq_o = mul_stall;
      if (rst) begin
         wd_o       = '0;
         wreg_o     = 1'b0;
         wdata_o    = '0;
         stallreq_o = 1'b0;
      end
   end

endmodule
